result_checker: RTL



---
 rtl/result_checker.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/result_checker.sv
// ---------------------------------------------------------------------------
// result_checker
//
// Purpose:
//   Read-side consumer of the result FIFO. For every vector of a run it pops
//   one captured result ({cycles, result}) and one expected entry
//   ({mask, expected}) together, compares them under the mask, keeps
//   pass/fail counters and, on a mismatch, writes a 3-word record into the
//   shared SRAM through the memory arbitration port:
//     word 0 : vector index
//     word 1 : result[15:0]
//     word 2 : {cycles zero-extended to 8 bits, result[RTF_WIDTH-1:16]
//               zero-extended to 8 bits}
//   Records are placed at LOG_BASE + 3*record + k. Once LOG_DEPTH records
//   exist, further mismatches are only counted and flag log_overflow.
//
// Configuration:
//   RESULT_CHECKER_STOP_ON_FAIL_EN - when defined, the run ends after the
//   first failing vector has been counted (and logged if there is room).
//   No further pops occur. When undefined, all vec_total vectors are run.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   start, vec_total     run launch pulse and vector count (sampled on start)
//   busy, done           run in progress / one-cycle completion pulse
//   rfifo_q/_rdempty/_rdreq  result FIFO read side (non-show-ahead)
//   efifo_q/_rdempty/_rdreq  expected FIFO read side (non-show-ahead)
//   address, write, writedata, waitrequest  log write master port
//   pass_count, fail_count, log_overflow    run statistics
// ---------------------------------------------------------------------------
module result_checker #(
  parameter int          ADDR_WIDTH  = 20,
  parameter int          DATA_WIDTH  = 16,
  parameter int          RTF_WIDTH   = 24,
  parameter int          CYCLE_RANGE = 5,
  parameter int unsigned LOG_BASE    = 32'h0008_0000,
  parameter int          LOG_DEPTH   = 256,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           vec_total,
  output logic                           busy,
  output logic                           done,
  input  logic [RTF_WIDTH+CYCLE_RANGE:0] rfifo_q,
  input  logic                           rfifo_rdempty,
  output logic                           rfifo_rdreq,
  input  logic [2*RTF_WIDTH-1:0]         efifo_q,
  input  logic                           efifo_rdempty,
  output logic                           efifo_rdreq,
  output logic [ADDR_WIDTH-1:0]          address,
  output logic                           write,
  output logic [DATA_WIDTH-1:0]          writedata,
  input  logic                           waitrequest,
  output logic [CNT_WIDTH-1:0]           pass_count,
  output logic [CNT_WIDTH-1:0]           fail_count,
  output logic                           log_overflow
);

  localparam int CYC_W = CYCLE_RANGE + 1;
  localparam int REC_W = $clog2(LOG_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_CMP,
    S_LOG0,
    S_LOG1,
    S_LOG2,
    S_FIN
  } state_e;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    total_q, total_d;
  logic [CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [REC_W-1:0]        rec_q, rec_d;
  logic [RTF_WIDTH-1:0]    res_q, res_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]    pass_q, pass_d;
  logic [CNT_WIDTH-1:0]    fail_q, fail_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rdreq_q, rdreq_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  // -------------------------------------------------------------------------
  // Compare datapath (FIFO q is valid in CMP, the cycle after the pop)
  // -------------------------------------------------------------------------
  logic [RTF_WIDTH-1:0]  cmp_res;
  logic [CYC_W-1:0]      cmp_cyc;
  logic [RTF_WIDTH-1:0]  cmp_exp;
  logic [RTF_WIDTH-1:0]  cmp_mask;
  logic                  mismatch;
  logic                  can_pop;
  logic                  rec_room;
  logic [ADDR_WIDTH-1:0] rec_ext;
  logic [ADDR_WIDTH-1:0] rec_base;

  assign cmp_res  = rfifo_q[RTF_WIDTH-1:0];
  assign cmp_cyc  = rfifo_q[RTF_WIDTH+CYCLE_RANGE:RTF_WIDTH];
  assign cmp_exp  = efifo_q[RTF_WIDTH-1:0];
  assign cmp_mask = efifo_q[2*RTF_WIDTH-1:RTF_WIDTH];
  assign mismatch = |((cmp_res ^ cmp_exp) & cmp_mask);

  // A pop is only legal when both sides have an entry, so the pair stays
  // aligned.
  assign can_pop  = !rfifo_rdempty && !efifo_rdempty;
  assign rec_room = (rec_q < REC_W'(LOG_DEPTH));

  // First word of the current record: LOG_BASE + 3*record.
  assign rec_ext  = ADDR_WIDTH'(rec_q);
  assign rec_base = ADDR_WIDTH'(LOG_BASE) + (rec_ext << 1) + rec_ext;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Decision taken whenever the checker is ready for the next vector.
  function automatic state_e next_vector(input logic [CNT_WIDTH-1:0] idx,
                                         input logic [CNT_WIDTH-1:0] total,
                                         input logic                 pop_ok);
    if (idx == total) begin
      return S_FIN;
    end else if (pop_ok) begin
      return S_POP;
    end
    return S_WAIT;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    res_d   = res_q;
    cyc_d   = cyc_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ovf_d   = ovf_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d = vec_total;
          idx_d   = '0;
          rec_d   = '0;
          pass_d  = '0;
          fail_d  = '0;
          ovf_d   = 1'b0;
          state_d = (vec_total == '0) ? S_FIN : S_WAIT;
        end
      end

      S_WAIT: begin
        state_d = next_vector(idx_q, total_q, can_pop);
      end

      // rdreq is high in this state; q arrives in CMP.
      S_POP: begin
        state_d = S_CMP;
      end

      S_CMP: begin
        // Keep the result so the log words survive later FIFO activity.
        res_d = cmp_res;
        cyc_d = cmp_cyc;
        if (!mismatch) begin
          pass_d  = sat_inc(pass_q);
          idx_d   = sat_inc(idx_q);
          state_d = S_WAIT;
        end else begin
          fail_d = sat_inc(fail_q);
          if (rec_room) begin
            addr_d  = rec_base;
            wdata_d = DATA_WIDTH'(idx_q);
            state_d = S_LOG0;
          end else begin
            ovf_d = 1'b1;
`ifdef RESULT_CHECKER_STOP_ON_FAIL_EN
            state_d = S_FIN;
`else
            idx_d   = sat_inc(idx_q);
            state_d = S_WAIT;
`endif
          end
        end
      end

      // Each log word advances only when the write is accepted; otherwise
      // address/writedata/write simply hold their registered values.
      S_LOG0: begin
        if (!waitrequest) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          wdata_d = DATA_WIDTH'(res_q[15:0]);
          state_d = S_LOG1;
        end
      end

      S_LOG1: begin
        if (!waitrequest) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          wdata_d = DATA_WIDTH'({8'(cyc_q), 8'(res_q[RTF_WIDTH-1:16])});
          state_d = S_LOG2;
        end
      end

      S_LOG2: begin
        if (!waitrequest) begin
          rec_d = rec_q + REC_W'(1);
`ifdef RESULT_CHECKER_STOP_ON_FAIL_EN
          state_d = S_FIN;
`else
          // Skip WAIT: the next pop may issue straight after the last word.
          idx_d   = sat_inc(idx_q);
          state_d = next_vector(idx_d, total_q, can_pop);
`endif
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered versions of what the next state implies.
  assign rdreq_d = (state_d == S_POP);
  assign write_d = (state_d inside {S_LOG0, S_LOG1, S_LOG2});
  assign done_d  = (state_d == S_FIN);
  assign busy_d  = (state_d inside {S_WAIT, S_POP, S_CMP, S_LOG0, S_LOG1, S_LOG2});

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      total_q <= '0;
      idx_q   <= '0;
      rec_q   <= '0;
      res_q   <= '0;
      cyc_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdreq_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
      res_q   <= res_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdreq_q <= rdreq_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rfifo_rdreq  = rdreq_q;
  assign efifo_rdreq  = rdreq_q;
  assign address      = addr_q;
  assign write        = write_q;
  assign writedata    = wdata_q;
  assign pass_count   = pass_q;
  assign fail_count   = fail_q;
  assign log_overflow = ovf_q;

endmodule
